// File: rtl/offload_dispatch.sv
// rtl/offload_dispatch.sv - job feeder: buffers input records and issues tagged requests under a credit window
module offload_dispatch #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUT    = 8,
  parameter int TAG_W      = 3,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  job_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [DATA_W-1:0] req_data,
  output logic [TAG_W-1:0]  req_tag,
  input  logic              rsp_valid,
  output logic              busy,
  output logic              done,
  output logic [TAG_W:0]    outstanding,
  output logic              err_rsp
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t             r_state;
  logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic [CNT_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_accepted;
  logic [CNT_W-1:0]   r_issued;
  logic [TAG_W-1:0]   r_tag;
  logic [TAG_W:0]     r_out;
  logic               r_done;
  logic               r_err;

  logic w_full;
  logic w_empty;
  logic w_credit_ok;
  logic w_push;
  logic w_pop;

  // Handshake qualifiers depend only on registered state, so no input reaches an output combinationally.
  assign w_full      = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_credit_ok = (r_out < (TAG_W+1)'(MAX_OUT));

  assign in_ready  = (r_state == S_RUN) && !w_full && (r_accepted < r_len);
  assign req_valid = (r_state == S_RUN) && !w_empty && w_credit_ok;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = req_valid && req_ready;

  assign req_data    = r_mem[r_rd_ptr];
  assign req_tag     = r_tag;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign outstanding = r_out;
  assign err_rsp     = r_err;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_len      <= '0;
      r_accepted <= '0;
      r_issued   <= '0;
      r_tag      <= '0;
      r_out      <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end

      // An issue and a response in the same cycle cancel; a lone stray response flags an error.
      if (w_pop && !rsp_valid) begin
        r_out <= r_out + 1'b1;
      end else if (!w_pop && rsp_valid) begin
        if (r_out == '0) begin
          r_err <= 1'b1;
        end else begin
          r_out <= r_out - 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (job_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state    <= S_RUN;
              r_len      <= job_len;
              r_accepted <= '0;
              r_issued   <= '0;
              r_tag      <= '0;
            end
          end
        end
        S_RUN: begin
          if (w_push) begin
            r_accepted <= r_accepted + 1'b1;
          end
          if (w_pop) begin
            r_issued <= r_issued + 1'b1;
            r_tag    <= r_tag + 1'b1;
            if (r_issued + CNT_W'(1) == r_len) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if ((r_out == '0) || ((r_out == (TAG_W+1)'(1)) && rsp_valid)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_offload_dispatch.sv
// tb/tb_offload_dispatch.sv - randomized scoreboard bench for offload_dispatch
module tb_offload_dispatch;

  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_OUT    = 8;
  localparam int TAG_W      = 3;
  localparam int CNT_W      = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              start;
  logic [CNT_W-1:0]  job_len;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_data;
  logic [TAG_W-1:0]  req_tag;
  logic              rsp_valid;
  logic              busy;
  logic              done;
  logic [TAG_W:0]    outstanding;
  logic              err_rsp;

  offload_dispatch #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUT(MAX_OUT), .TAG_W(TAG_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .job_len(job_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .busy(busy), .done(done), .outstanding(outstanding), .err_rsp(err_rsp)
  );

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [TAG_W-1:0]  t;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   use_seq = 1'b0;

  // Job-level reference: counts of records accepted, issued and answered.
  bit m_active, m_done, m_err;
  int m_len, m_acc, m_iss, m_out;

  bit e_in_ready, e_req_valid, e_busy, e_done, e_err;
  int e_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_active = 0; m_done = 0; m_err = 0;
    m_len = 0; m_acc = 0; m_iss = 0; m_out = 0;
  endtask

  // One clock of stimulus: publish expectations, drive inputs, advance the model.
  task automatic step(input bit rst, input bit st, input int jl, input int pin,
                      input int prdy, input int prsp, input bit stray_rsp);
    bit inf, rqf, drain;
    @(negedge clk);
    e_busy      = m_active;
    e_done      = m_done;
    e_err       = m_err;
    e_out       = m_out;
    e_in_ready  = m_active && (m_iss < m_len) && (m_acc < m_len) && ((m_acc - m_iss) < FIFO_DEPTH);
    e_req_valid = m_active && (m_iss < m_len) && (m_acc > m_iss) && (m_out < MAX_OUT);

    reset     = !rst;
    start     = st && !rst;
    job_len   = CNT_W'(jl);
    in_valid  = !rst && ($urandom_range(99) < pin);
    in_data   = use_seq ? DATA_W'(32'h10 + m_acc) : DATA_W'($urandom);
    req_ready = !rst && ($urandom_range(99) < prdy);
    rsp_valid = !rst && (stray_rsp || ((m_out > 0) && ($urandom_range(99) < prsp)));

    if (rst) begin
      model_clear();
      exp_q.delete();
    end else begin
      inf   = in_valid && e_in_ready;
      rqf   = req_ready && e_req_valid;
      drain = m_active && (m_iss == m_len);
      m_done = 0;
      if (inf) begin
        exp_q.push_back({in_data, TAG_W'(m_acc)});
        m_acc++;
      end
      if (rqf) m_iss++;
      if (rqf && !rsp_valid) m_out++;
      else if (!rqf && rsp_valid) begin
        if (m_out == 0) m_err = 1;
        else m_out--;
      end
      if (!m_active && st) begin
        if (jl == 0) m_done = 1;
        else begin
          m_active = 1; m_len = jl; m_acc = 0; m_iss = 0;
        end
      end else if (drain && (m_out == 0)) begin
        m_active = 0;
        m_done   = 1;
      end
    end
  endtask

  task automatic run_until_idle(input int pin, input int prdy, input int prsp);
    int n = 0;
    while (m_active && (n < 400)) begin
      step(0, 0, 0, pin, prdy, prsp, 0);
      n++;
    end
    checks++;
    if (m_active) begin
      errors++;
      $display("FAIL job_timeout actual=busy expected=idle t=%0t", $time);
    end
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares the DUT against the published expectations, pops the scoreboard on each issue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        chk("busy", 64'(busy), 64'(e_busy));
        chk("done", 64'(done), 64'(e_done));
        chk("err_rsp", 64'(err_rsp), 64'(e_err));
        chk("outstanding", 64'(outstanding), 64'(e_out));
        chk("in_ready", 64'(in_ready), 64'(e_in_ready));
        chk("req_valid", 64'(req_valid), 64'(e_req_valid));
        if (done) chk("done_with_busy", 64'(busy), 64'(0));
        if (req_valid && req_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_request actual=%0h expected=none t=%0t", req_data, $time);
          end else begin
            e = exp_q.pop_front();
            chk("req_data", 64'(req_data), 64'(e.d));
            chk("req_tag", 64'(req_tag), 64'(e.t));
          end
        end
      end
    end
  end

  initial begin
    int n;
    reset = 0; start = 0; job_len = '0; in_valid = 0; in_data = '0; req_ready = 0; rsp_valid = 0;
    model_clear();

    step(1, 0, 0, 0, 0, 0, 0);
    mon_en = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Basic job with sequential data 0x10..0x14
    use_seq = 1'b1;
    step(0, 1, 5, 100, 100, 40, 0);
    run_until_idle(100, 100, 40);
    use_seq = 1'b0;

    // Credit window: no responses for 20 cycles, then one per cycle
    step(0, 1, 12, 100, 100, 0, 0);
    repeat (20) step(0, 0, 0, 100, 100, 0, 0);
    run_until_idle(100, 100, 100);

    // Backpressure: accelerator stalled for 10 cycles
    step(0, 1, 6, 100, 0, 0, 0);
    repeat (10) step(0, 0, 0, 100, 0, 0, 0);
    run_until_idle(100, 100, 50);

    // Zero-length job and start ignored while busy
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 70, 70, 50, 0);
    repeat (3) step(0, 0, 0, 70, 70, 50, 0);
    step(0, 1, 9, 70, 70, 50, 0);
    run_until_idle(70, 70, 50);

    // Stray response in IDLE sets a sticky error that survives a job
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 4, 100, 100, 60, 0);
    run_until_idle(100, 100, 60);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Reset mid-job with records buffered and requests in flight
    step(0, 1, 10, 100, 50, 0, 0);
    n = 0;
    while (!((m_out >= 3) && ((m_acc - m_iss) >= 2)) && (n < 100)) begin
      step(0, 0, 0, 100, 50, 0, 0);
      n++;
    end
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Randomized jobs
    for (int j = 0; j < 25; j++) begin
      int pin, prdy, prsp;
      pin  = $urandom_range(100, 20);
      prdy = $urandom_range(100, 20);
      prsp = $urandom_range(90, 10);
      step(0, 1, $urandom_range(20), pin, prdy, prsp, 0);
      repeat ($urandom_range(4)) step(0, ($urandom_range(3) == 0), $urandom_range(20), pin, prdy, prsp, 0);
      run_until_idle(pin, prdy, prsp);
    end

    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/offload_dispatch.md
Name: offload_dispatch

Overview:
- Upstream feeder for the Offloaded accelerator.
- Accepts a job of N input records on a ready/valid stream and buffers them in a small FIFO.
- Issues each record to the accelerator request port with a rolling tag, limited by a credit window of outstanding requests.
- Retires credits as responses return, and pulses done once every record has been issued and answered.

Parameters:
- DATA_W, 32, record width.
- FIFO_DEPTH, 4, input buffer entries; must be a power of 2, minimum 2.
- MAX_OUT, 8, maximum requests in flight.
- TAG_W, 3, request tag width; tags wrap modulo 2^TAG_W.
- CNT_W, 16, job length and record counter width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low; 0 = reset.
- start  in  1  job start pulse; honoured only in IDLE.
- job_len  in  CNT_W  record count for the job; sampled when start is honoured.
- in_valid  in  1  input record valid.
- in_ready  out  1  input record accepted when in_valid and in_ready are both 1.
- in_data  in  DATA_W  input record.
- req_valid  out  1  request to accelerator valid.
- req_ready  in  1  accelerator accepts the request.
- req_data  out  DATA_W  request record (FIFO head).
- req_tag  out  TAG_W  request tag.
- rsp_valid  in  1  one accelerator response completes.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse at job completion.
- outstanding  out  TAG_W+1  requests in flight.
- err_rsp  out  1  sticky: rsp_valid seen while outstanding == 0.

Behaviour:
- Reset (reset == 0 at a clock edge):
  - State goes to IDLE; FIFO is emptied.
  - All counters and the tag are cleared.
  - in_ready, req_valid, busy, done, outstanding and err_rsp are all 0.
  - Reset mid-job abandons the job; in-flight responses arriving after reset raise err_rsp.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start with job_len != 0: go to RUN. Load len_q = job_len and clear accepted, issued and tag.
  - start with job_len == 0: stay in IDLE and assert done for one cycle on the next cycle.
  - All other inputs are ignored; in_ready = 0 and req_valid = 0.
- RUN:
  - in_ready = fifo_not_full AND (accepted < len_q). in_ready does not depend on req_ready in the same cycle (no combinational pass-through).
  - An accepted record increments accepted and is written to the FIFO.
  - Minimum input-to-request latency is 1 cycle: a record accepted at edge N can be presented on req_data after edge N.
  - req_valid = fifo_not_empty AND (outstanding < MAX_OUT).
  - req_data and req_tag must stay stable while req_valid = 1 and req_ready = 0.
  - On a request handshake: pop the FIFO, issued += 1, tag += 1 (wraps at 2^TAG_W), outstanding += 1.
  - When issued reaches len_q: go to DRAIN.
- DRAIN:
  - in_ready = 0 and req_valid = 0.
  - When outstanding == 0 (including the case where the final decrement happens this cycle): go to IDLE and pulse done on the following cycle.
- Outstanding accounting:
  - Request handshake and rsp_valid in the same cycle leave outstanding unchanged.
  - rsp_valid alone decrements outstanding, saturating at 0; if outstanding was already 0, err_rsp is set.
  - err_rsp clears only on reset.
- Credit boundary: with outstanding == MAX_OUT, req_valid = 0. A response in that cycle allows req_valid = 1 on the next cycle, not the same one.
- FIFO full and empty conditions are mutually exclusive (use an occupancy count). Simultaneous push and pop while full is not possible because in_ready = 0 when full; simultaneous push and pop while non-full keeps the count.
- start during RUN or DRAIN is ignored; job_len is not resampled.
- busy = 1 in RUN and DRAIN. done is never asserted together with busy.

Test Plan:
- Basic job: reset low 2 cycles; start with job_len = 5; in_valid held high with data 0x10..0x14; req_ready = 1; each rsp_valid 3 cycles after its issue -> req_data 0x10..0x14 with tags 0..4 in order, exactly 5 request handshakes, one done pulse, busy then returns to 0, outstanding returns to 0.
- Credit limit: job_len = 12, MAX_OUT = 8, req_ready = 1, no responses until cycle 20 -> exactly 8 requests, then req_valid held 0. Release one response per cycle -> one new issue per cycle after each response; tags wrap 7 -> 0.
- Backpressure: req_ready = 0 for 10 cycles, job_len = 6 -> in_ready drops after 4 accepts (FIFO full); req_data and req_tag stay stable; after release, all 6 records are issued in order.
- Zero length and ignored start: start with job_len = 0 -> done = 1 next cycle, busy stays 0. During a job, a second start with job_len = 9 -> ignored, original length honoured.
- Simultaneous events: at outstanding = 3, issue and rsp_valid in the same cycle -> outstanding stays 3. rsp_valid in IDLE with outstanding = 0 -> err_rsp = 1 and stays 1 until reset.
- Reset mid-job: reset = 0 during RUN with 2 records in the FIFO and 3 outstanding -> next cycle state IDLE, FIFO empty, outstanding 0, all outputs at reset values, no done pulse.
